buffer_arbiter: RTL and testbench

BUFFER_ARBITER -- requirements
Module: buffer_arbiter

---
 rtl/buffer_arbiter_pkg.sv | 15 +
 rtl/buffer_arbiter_if.sv | 35 +++
 rtl/buffer_arbiter_rr_pick.sv | 30 +++
 rtl/buffer_arbiter.sv | 130 +++++++++++++
 tb/tb_buffer_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/buffer_arbiter_pkg.sv
// Shared definitions for the buffer arbiter: FSM state encoding and default sizes.
package buffer_arbiter_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_e;

   localparam int DEF_WIDTH        = 32;
   localparam int DEF_N            = 4;
   localparam int DEF_LOG_N        = 2;
   localparam int DEF_MEM_SIZE     = 64;
   localparam int DEF_LOG_MEM_SIZE = 6;

endpackage

// File: rtl/buffer_arbiter_if.sv
// Requester-side and buffer-side signals of the buffer arbiter, bundled as one interface.
interface buffer_arbiter_if
   import buffer_arbiter_pkg::*;
#(
   parameter int WIDTH        = DEF_WIDTH,
   parameter int N            = DEF_N,
   parameter int LOG_N        = DEF_LOG_N,
   parameter int LOG_MEM_SIZE = DEF_LOG_MEM_SIZE
);

   logic [N-1:0]          in_valid;
   logic [N*WIDTH-1:0]    in_data;
   logic [N-1:0]          in_last;
   logic [N-1:0]          in_ready;
   logic                  write_strobe;
   logic [WIDTH-1:0]      write_data;
   logic [LOG_N-1:0]      write_src;
   logic                  read_delete;
   logic                  read_full;
   logic [LOG_MEM_SIZE:0] occupancy;
   logic                  error;

   // The arbiter itself
   modport slave (
      input  in_valid, in_data, in_last, read_delete, read_full,
      output in_ready, write_strobe, write_data, write_src, occupancy, error
   );

   // Requesters plus downstream buffer, seen from outside the arbiter
   modport master (
      output in_valid, in_data, in_last, read_delete, read_full,
      input  in_ready, write_strobe, write_data, write_src, occupancy, error
   );

endinterface

// File: rtl/buffer_arbiter_rr_pick.sv
// Round-robin priority pick: first asserted request searching ptr, ptr+1, ... mod N.
module rr_pick
   import buffer_arbiter_pkg::*;
#(
   parameter int N     = DEF_N,
   parameter int LOG_N = DEF_LOG_N
) (
   input  logic [N-1:0]     req_i,
   input  logic [LOG_N-1:0] ptr_i,
   output logic             found_o,
   output logic [LOG_N-1:0] idx_o
);

   logic [LOG_N-1:0] cand;

   // N is a power of two, so the LOG_N-bit sum wraps modulo N by itself
   always_comb begin
      found_o = 1'b0;
      idx_o   = '0;
      cand    = '0;
      for (int unsigned i = 0; i < N; i++) begin
         cand = ptr_i + LOG_N'(i);
         if (!found_o && req_i[cand]) begin
            found_o = 1'b1;
            idx_o   = cand;
         end
      end
   end

endmodule

// File: rtl/buffer_arbiter.sv
// Packet-level round-robin arbiter feeding a MEM_SIZE-deep buffer, tracking its occupancy.
module buffer_arbiter
   import buffer_arbiter_pkg::*;
#(
   parameter int WIDTH        = DEF_WIDTH,
   parameter int N            = DEF_N,
   parameter int LOG_N        = DEF_LOG_N,
   parameter int MEM_SIZE     = DEF_MEM_SIZE,
   parameter int LOG_MEM_SIZE = DEF_LOG_MEM_SIZE
) (
   input logic             clk,
   input logic             rst,
   buffer_arbiter_if.slave bus
);

   localparam logic [LOG_MEM_SIZE:0] OccMax = (LOG_MEM_SIZE+1)'(MEM_SIZE);
   localparam logic [LOG_MEM_SIZE:0] OccOne = (LOG_MEM_SIZE+1)'(1);

   state_e                state_q, state_d;
   logic [LOG_N-1:0]      g_q, g_d;
   logic [LOG_N-1:0]      p_q, p_d;
   logic [LOG_MEM_SIZE:0] occ_q, occ_d;
   logic                  err_q, err_d;
   logic                  wstrb_q, wstrb_d;
   logic [WIDTH-1:0]      wdata_q, wdata_d;
   logic [LOG_N-1:0]      wsrc_q, wsrc_d;

   logic [WIDTH-1:0]      words [N];
   logic [N-1:0]          ready;
   logic                  pick_found;
   logic [LOG_N-1:0]      pick_idx;
   logic                  has_room;
   logic                  accept;
   logic                  delete;
   logic                  do_dec;

   rr_pick #(
      .N     (N),
      .LOG_N (LOG_N)
   ) u_rr_pick (
      .req_i   (bus.in_valid),
      .ptr_i   (p_q),
      .found_o (pick_found),
      .idx_o   (pick_idx)
   );

   always_comb begin
      for (int unsigned i = 0; i < N; i++) begin
         words[i] = bus.in_data[i*WIDTH +: WIDTH];
      end
   end

   always_comb begin
      // Readiness looks only at registered occupancy, so a delete this cycle cannot reopen a full buffer
      has_room = (occ_q < OccMax);
      ready    = '0;
      if (state_q == GRANT) begin
         ready[g_q] = has_room;
      end
      accept = (state_q == GRANT) && bus.in_valid[g_q] && has_room;
      delete = bus.read_delete && bus.read_full;
      do_dec = delete && (occ_q != '0);

      state_d = state_q;
      g_d     = g_q;
      p_d     = p_q;
      wstrb_d = accept;
      wdata_d = wdata_q;
      wsrc_d  = wsrc_q;
      err_d   = err_q | (delete && (occ_q == '0));
      occ_d   = occ_q;

      if (accept) begin
         wdata_d = words[g_q];
         wsrc_d  = g_q;
      end

      if (accept && !do_dec) begin
         occ_d = occ_q + OccOne;
      end else if (!accept && do_dec) begin
         occ_d = occ_q - OccOne;
      end

      case (state_q)
         IDLE: begin
            if (pick_found) begin
               g_d     = pick_idx;
               state_d = GRANT;
            end
         end
         GRANT: begin
            if (accept && bus.in_last[g_q]) begin
               state_d = IDLE;
               p_d     = g_q + LOG_N'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         g_q     <= '0;
         p_q     <= '0;
         occ_q   <= '0;
         err_q   <= 1'b0;
         wstrb_q <= 1'b0;
         wdata_q <= '0;
         wsrc_q  <= '0;
      end else begin
         state_q <= state_d;
         g_q     <= g_d;
         p_q     <= p_d;
         occ_q   <= occ_d;
         err_q   <= err_d;
         wstrb_q <= wstrb_d;
         wdata_q <= wdata_d;
         wsrc_q  <= wsrc_d;
      end
   end

   assign bus.in_ready     = ready;
   assign bus.write_strobe = wstrb_q;
   assign bus.write_data   = wdata_q;
   assign bus.write_src    = wsrc_q;
   assign bus.occupancy    = occ_q;
   assign bus.error        = err_q;

endmodule

// File: tb/tb_buffer_arbiter.sv
// Bench for buffer_arbiter: packet-level reference model compared every cycle, plus directed scenarios.
module tb_buffer_arbiter;

   localparam int W   = 32;
   localparam int N   = 4;
   localparam int LN  = 2;
   localparam int MS  = 64;
   localparam int LMS = 6;

   logic clk;
   logic rst;

   buffer_arbiter_if #(.WIDTH(W), .N(N), .LOG_N(LN), .LOG_MEM_SIZE(LMS)) bus ();

   buffer_arbiter #(
      .WIDTH        (W),
      .N            (N),
      .LOG_N        (LN),
      .MEM_SIZE     (MS),
      .LOG_MEM_SIZE (LMS)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   function automatic void chk(input string nm, input longint unsigned act, input longint unsigned exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endfunction

   // Reference model: owner of the current packet (-1 when nobody holds the grant),
   // next-in-turn requester, and a plain word count for the buffer.
   int          m_owner = -1;
   int          m_ptr   = 0;
   int          m_count = 0;
   bit          m_err   = 0;
   bit          m_wr    = 0;
   logic [W-1:0] m_wdata = '0;
   int          m_wsrc  = 0;
   int          cyc     = 0;
   bit          armed   = 0;
   bit          m_acc, m_del, m_found;
   int          m_r;

   always @(posedge clk) begin
      if (rst) begin
         m_owner = -1; m_ptr = 0; m_count = 0; m_err = 0;
         m_wr = 0; m_wdata = '0; m_wsrc = 0;
         cyc = 1; armed = 1;
      end else begin
         cyc++;
         m_acc = (m_owner >= 0) && (m_count < MS) && bus.in_valid[m_owner];
         m_del = bus.read_delete && bus.read_full;
         m_wr  = m_acc;
         if (m_acc) begin
            m_wdata = bus.in_data[m_owner*W +: W];
            m_wsrc  = m_owner;
         end
         if (m_del && m_count == 0) m_err = 1;
         m_count = m_count + (m_acc ? 1 : 0) - ((m_del && m_count > 0) ? 1 : 0);
         if (m_owner < 0) begin
            m_found = 0;
            for (int k = 0; k < N; k++) begin
               m_r = (m_ptr + k) % N;
               if (!m_found && bus.in_valid[m_r]) begin
                  m_found = 1;
                  m_owner = m_r;
               end
            end
         end else if (m_acc && bus.in_last[m_owner]) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
         end
      end
   end

   function automatic logic [N-1:0] exp_ready();
      if (m_owner >= 0 && m_count < MS) return N'(1) << m_owner;
      return '0;
   endfunction

   int           wl_src [$];
   logic [W-1:0] wl_data[$];
   int           wl_cyc [$];

   always @(negedge clk) begin
      if (armed) begin
         chk("in_ready", bus.in_ready, exp_ready());
         chk("write_strobe", bus.write_strobe, m_wr);
         if (m_wr) begin
            chk("write_data", bus.write_data, m_wdata);
            chk("write_src", bus.write_src, m_wsrc);
         end
         chk("occupancy", bus.occupancy, m_count);
         chk("error", bus.error, m_err);
         if (bus.write_strobe === 1'b1) begin
            wl_src.push_back(int'(bus.write_src));
            wl_data.push_back(bus.write_data);
            wl_cyc.push_back(cyc);
         end
      end
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic sample();
      @(negedge clk); #1;
   endtask

   task automatic do_reset();
      bus.in_valid    = '0;
      bus.in_data     = '0;
      bus.in_last     = '0;
      bus.read_delete = 1'b0;
      bus.read_full   = 1'b0;
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      wl_src.delete();
      wl_data.delete();
      wl_cyc.delete();
   endtask

   // Offer nwords words (base, base+1, ...) from one requester for ncycles cycles.
   task automatic stream(input int src, input int nwords, input int ncycles,
                         input logic [W-1:0] base, output int nacc);
      bit acc;
      int idx = 0;
      for (int c = 0; c < ncycles; c++) begin
         bus.in_valid[src]         = (idx < nwords);
         bus.in_data[src*W +: W]   = base + W'(idx);
         bus.in_last[src]          = (idx == nwords - 1);
         @(negedge clk);
         acc = bus.in_valid[src] && bus.in_ready[src];
         step();
         if (acc) idx++;
      end
      if (idx >= nwords) begin
         bus.in_valid[src] = 1'b0;
         bus.in_last[src]  = 1'b0;
      end
      nacc = idx;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached, got no finish, expected finish");
      $fatal(1, "watchdog");
   end

   int n;
   int exp_rr[5] = '{0, 1, 2, 3, 0};

   initial begin
      rst = 1'b1;
      bus.in_valid = '0; bus.in_data = '0; bus.in_last = '0;
      bus.read_delete = 1'b0; bus.read_full = 1'b0;

      // Reset values
      do_reset();
      sample();
      chk("rst_in_ready", bus.in_ready, 0);
      chk("rst_write_strobe", bus.write_strobe, 0);
      chk("rst_write_data", bus.write_data, 0);
      chk("rst_write_src", bus.write_src, 0);
      chk("rst_occupancy", bus.occupancy, 0);
      chk("rst_error", bus.error, 0);

      // Single packet from requester 2: grant in cycle 1, writes in cycles 3..5
      do_reset();
      stream(2, 3, 6, W'('hA1), n);
      sample();
      chk("s1_accepted", n, 3);
      chk("s1_nwrites", wl_src.size(), 3);
      for (int i = 0; i < 3 && i < wl_src.size(); i++) begin
         chk("s1_src", wl_src[i], 2);
         chk("s1_data", wl_data[i], 'hA1 + i);
         chk("s1_cycle", wl_cyc[i], 3 + i);
      end
      chk("s1_occupancy", bus.occupancy, 3);

      // Round robin with all four holding 1-word packets
      do_reset();
      for (int i = 0; i < N; i++) bus.in_data[i*W +: W] = W'('hB0 + i);
      bus.in_last  = '1;
      bus.in_valid = '1;
      repeat (12) step();
      bus.in_valid = '0;
      step();
      sample();
      chk("s2_nwrites_ge5", (wl_src.size() >= 5), 1);
      for (int i = 0; i < 5 && i < wl_src.size(); i++) begin
         chk("s2_order", wl_src[i], exp_rr[i]);
         chk("s2_data", wl_data[i], 'hB0 + exp_rr[i]);
         if (i > 0) chk("s2_gap", wl_cyc[i] - wl_cyc[i-1], 2);
      end

      // No interleave: 5-word packet from 0 while 1 waits
      do_reset();
      bus.in_data[1*W +: W] = W'('hC1);
      bus.in_last[1]  = 1'b1;
      bus.in_valid[1] = 1'b1;
      stream(0, 5, 8, W'('hD0), n);
      repeat (3) step();
      bus.in_valid[1] = 1'b0;
      step();
      sample();
      chk("s3_accepted", n, 5);
      chk("s3_nwrites_ge6", (wl_src.size() >= 6), 1);
      for (int i = 0; i < 5 && i < wl_src.size(); i++) begin
         chk("s3_src0", wl_src[i], 0);
         chk("s3_data0", wl_data[i], 'hD0 + i);
         chk("s3_consec", wl_cyc[i] - wl_cyc[0], i);
      end
      if (wl_src.size() >= 6) begin
         chk("s3_src1", wl_src[5], 1);
         chk("s3_data1", wl_data[5], 'hC1);
      end

      // Backpressure: 70 words offered into a 64-deep buffer, then one delete
      do_reset();
      stream(3, 70, 80, W'('h1000), n);
      chk("s4_accepted", n, 64);
      @(negedge clk);
      #1;
      chk("s4_nwrites", wl_src.size(), 64);
      chk("s4_occ_full", bus.occupancy, 64);
      chk("s4_ready_full", bus.in_ready, 0);
      bus.read_delete = 1'b1;
      bus.read_full   = 1'b1;
      step();
      bus.read_delete = 1'b0;
      bus.read_full   = 1'b0;
      sample();
      chk("s4_occ_after_del", bus.occupancy, 63);
      chk("s4_ready_after_del", bus.in_ready, 4'b1000);
      step();
      sample();
      chk("s4_occ_refill", bus.occupancy, 64);
      chk("s4_ready_refill", bus.in_ready, 0);
      repeat (4) step();
      sample();
      chk("s4_nwrites_final", wl_src.size(), 65);
      if (wl_data.size() == 65) chk("s4_last_data", wl_data[64], 'h1000 + 64);

      // Accept and delete together at occupancy 10; delete without read_full ignored
      do_reset();
      stream(1, 30, 11, W'('h2000), n);
      chk("s5_accepted", n, 10);
      sample();
      chk("s5_occ10", bus.occupancy, 10);
      chk("s5_ready", bus.in_ready, 4'b0010);
      bus.read_delete = 1'b1;
      bus.read_full   = 1'b1;
      step();
      bus.read_full   = 1'b0;
      bus.in_valid[1] = 1'b0;
      sample();
      chk("s5_occ_same", bus.occupancy, 10);
      chk("s5_strobe", bus.write_strobe, 1);
      step();
      bus.read_delete = 1'b0;
      sample();
      chk("s5_occ_nofull", bus.occupancy, 10);
      repeat (3) step();
      sample();
      chk("s5_wait_grant", bus.in_ready, 4'b0010);
      chk("s5_no_error", bus.error, 0);

      // Delete on empty buffer sets a sticky error
      do_reset();
      bus.read_delete = 1'b1;
      bus.read_full   = 1'b1;
      step();
      bus.read_delete = 1'b0;
      bus.read_full   = 1'b0;
      sample();
      chk("s6_error_set", bus.error, 1);
      chk("s6_occ_zero", bus.occupancy, 0);
      repeat (3) step();
      sample();
      chk("s6_error_sticky", bus.error, 1);
      do_reset();
      sample();
      chk("s6_error_cleared", bus.error, 0);

      // Reset mid-packet; pointer must return to 0
      do_reset();
      stream(2, 1, 3, W'('h30), n);
      chk("s7_pkt2", n, 1);
      stream(1, 4, 3, W'('h40), n);
      chk("s7_partial", n, 2);
      rst = 1'b1;
      bus.in_valid = 4'b1010;
      step();
      rst = 1'b0;
      sample();
      chk("s7_strobe", bus.write_strobe, 0);
      chk("s7_data", bus.write_data, 0);
      chk("s7_src", bus.write_src, 0);
      chk("s7_occ", bus.occupancy, 0);
      chk("s7_ready", bus.in_ready, 0);
      chk("s7_error", bus.error, 0);
      step();
      sample();
      chk("s7_ptr_zero", bus.in_ready, 4'b0010);
      bus.in_valid = '0;
      repeat (3) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
